mem_wb_stage: RTL and testbench

MEM stage of the 5-stage pipeline. It consumes the EX/MEM register outputs, runs load/store accesses against a variable-latency data memory over a req/ack handshake, and resolves beq. It also holds the MEM/WB register that feeds write-back. While an access is pending it raises stall so the upstream stages and the EX/MEM register hold.

---
 rtl/mem_wb_stage_pkg.sv | 17 +
 rtl/mem_wb_register.sv | 40 ++++
 rtl/mem_wb_stage.sv | 157 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM stage and the MEM/WB register.
package mem_wb_stage_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    localparam wb_ctrl_t BUBBLE_CTRL = '{mem_to_reg: 1'b0, reg_write: 1'b0};
endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register; a bubble clears control and data so WB sees a clean no-op.
module mem_wb_register
    import mem_wb_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              bubble,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [REG_W-1:0]  reg_rd_in,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  reg_rd_out
);
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            mem_to_reg_out <= 1'b0;
            reg_write_out  <= 1'b0;
            read_data_out  <= '0;
            alu_result_out <= '0;
            reg_rd_out     <= '0;
        end else if (bubble) begin
            mem_to_reg_out <= BUBBLE_CTRL.mem_to_reg;
            reg_write_out  <= BUBBLE_CTRL.reg_write;
            read_data_out  <= '0;
            alu_result_out <= '0;
            reg_rd_out     <= '0;
        end else begin
            mem_to_reg_out <= mem_to_reg_in;
            reg_write_out  <= reg_write_in;
            read_data_out  <= read_data_in;
            alu_result_out <= alu_result_in;
            reg_rd_out     <= reg_rd_in;
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data memory req/ack access with timeout abort, beq resolve, MEM/WB register.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              beq_instruction_in,
    input  logic              flag_beq_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mux2_result_in,
    input  logic [REG_W-1:0]  reg_rd_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_out,
    output logic              pc_src_out,
    output logic              mem_error,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  reg_rd_out
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              req_n, we_n, err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    wb_ctrl_t          lat_ctrl, lat_ctrl_n;
    logic [DATA_W-1:0] lat_alu, lat_alu_n;
    logic [REG_W-1:0]  lat_rd, lat_rd_n;

    logic              access, legal, bubble;
    logic              wb_mtr, wb_rw;
    logic [DATA_W-1:0] wb_rdata, wb_alu;
    logic [REG_W-1:0]  wb_rd;

    assign access     = mem_read_in | mem_write_in;
    assign legal      = (alu_result_in[1:0] == 2'b00) && !(mem_read_in && mem_write_in);
    assign pc_src_out = beq_instruction_in & flag_beq_in;

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_error <= 1'b0;
            lat_ctrl  <= BUBBLE_CTRL;
            lat_alu   <= '0;
            lat_rd    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_error <= err_n;
            lat_ctrl  <= lat_ctrl_n;
            lat_alu   <= lat_alu_n;
            lat_rd    <= lat_rd_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        req_n      = mem_req;
        we_n       = mem_we;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        err_n      = mem_error;
        lat_ctrl_n = lat_ctrl;
        lat_alu_n  = lat_alu;
        lat_rd_n   = lat_rd;
        stall_out  = 1'b0;
        bubble     = 1'b1;
        wb_mtr     = mem_to_reg_in;
        wb_rw      = reg_write_in;
        wb_rdata   = '0;
        wb_alu     = alu_result_in;
        wb_rd      = reg_rd_in;
        case (state)
            IDLE: begin
                if (!access) begin
                    bubble = 1'b0;
                end else if (!legal) begin
                    err_n = 1'b1;
                end else begin
                    stall_out  = 1'b1;
                    state_n    = WAIT;
                    cnt_n      = '0;
                    req_n      = 1'b1;
                    we_n       = mem_write_in;
                    addr_n     = ADDR_W'(alu_result_in);
                    wdata_n    = mux2_result_in;
                    lat_ctrl_n = '{mem_to_reg: mem_to_reg_in, reg_write: reg_write_in};
                    lat_alu_n  = alu_result_in;
                    lat_rd_n   = reg_rd_in;
                end
            end
            WAIT: begin
                // ack on the final timeout cycle still completes the access
                if (mem_ack) begin
                    bubble   = 1'b0;
                    wb_mtr   = lat_ctrl.mem_to_reg;
                    wb_rw    = lat_ctrl.reg_write;
                    wb_rdata = mem_we ? '0 : mem_rdata;
                    wb_alu   = lat_alu;
                    wb_rd    = lat_rd;
                    req_n    = 1'b0;
                    state_n  = IDLE;
                end else if (cnt == LAST) begin
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    stall_out = 1'b1;
                    cnt_n     = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    mem_wb_register u_mem_wb (
        .clock          (clock),
        .reset          (reset),
        .bubble         (bubble),
        .mem_to_reg_in  (wb_mtr),
        .reg_write_in   (wb_rw),
        .read_data_in   (wb_rdata),
        .alu_result_in  (wb_alu),
        .reg_rd_in      (wb_rd),
        .mem_to_reg_out (mem_to_reg_out),
        .reg_write_out  (reg_write_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .reg_rd_out     (reg_rd_out)
    );
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: transaction-level model checked every rising edge, plus literal checks.
module tb_mem_wb_stage;
    localparam int T = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in;
    logic        beq_instruction_in, flag_beq_in;
    logic [31:0] alu_result_in, mux2_result_in, mem_rdata;
    logic [4:0]  reg_rd_in;
    logic        mem_ack;
    logic        mem_req, mem_we, stall_out, pc_src_out, mem_error;
    logic [31:0] mem_addr, mem_wdata, read_data_out, alu_result_out;
    logic        mem_to_reg_out, reg_write_out;
    logic [4:0]  reg_rd_out;

    int checks = 0;
    int errors = 0;
    bit run = 0;

    mem_wb_stage #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .beq_instruction_in(beq_instruction_in), .flag_beq_in(flag_beq_in),
        .alu_result_in(alu_result_in), .mux2_result_in(mux2_result_in), .reg_rd_in(reg_rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_out(stall_out), .pc_src_out(pc_src_out), .mem_error(mem_error),
        .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out), .reg_rd_out(reg_rd_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding transaction, tracked by its age in WAIT edges.
    bit        pend;
    int        age;
    bit        p_load, p_mtr, p_rw;
    bit [31:0] p_alu;
    bit [4:0]  p_rd;
    bit        e_req, e_we, e_err, e_mtr, e_rw;
    bit [31:0] e_addr, e_wdata, e_rdata, e_alu;
    bit [4:0]  e_rd;

    function automatic bit is_access();
        return mem_read_in || mem_write_in;
    endfunction
    function automatic bit is_legal();
        return (alu_result_in % 4 == 0) && !(mem_read_in && mem_write_in);
    endfunction

    task automatic wb_bubble();
        {e_mtr, e_rw, e_rdata, e_alu, e_rd} = '0;
    endtask

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            pend = 0; age = 0;
            {e_req, e_we, e_err, e_addr, e_wdata} = '0;
            wb_bubble();
        end else if (!pend) begin
            if (!is_access()) begin
                e_mtr = mem_to_reg_in; e_rw = reg_write_in; e_rdata = 0;
                e_alu = alu_result_in; e_rd = reg_rd_in;
            end else if (!is_legal()) begin
                e_err = 1; wb_bubble();
            end else begin
                pend = 1; age = 0;
                p_load = mem_read_in; p_mtr = mem_to_reg_in; p_rw = reg_write_in;
                p_alu = alu_result_in; p_rd = reg_rd_in;
                e_req = 1; e_we = mem_write_in; e_addr = alu_result_in; e_wdata = mux2_result_in;
                wb_bubble();
            end
        end else if (mem_ack) begin
            pend = 0; e_req = 0;
            e_mtr = p_mtr; e_rw = p_rw; e_rdata = p_load ? mem_rdata : 0;
            e_alu = p_alu; e_rd = p_rd;
        end else if (age == T - 1) begin
            pend = 0; e_req = 0; e_err = 1; wb_bubble();
        end else begin
            age++; wb_bubble();
        end
    end

    always @(posedge clock) begin
        if (run) begin
            chk("mem_req", mem_req, e_req);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("mem_error", mem_error, e_err);
            chk("stall_out", stall_out,
                pend ? (!mem_ack && age != T - 1) : (is_access() && is_legal()));
            chk("pc_src_out", pc_src_out, beq_instruction_in && flag_beq_in);
            chk("mem_to_reg_out", mem_to_reg_out, e_mtr);
            chk("reg_write_out", reg_write_out, e_rw);
            chk("read_data_out", read_data_out, e_rdata);
            chk("alu_result_out", alu_result_out, e_alu);
            chk("reg_rd_out", reg_rd_out, e_rd);
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic idle_in();
        {mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in} = '0;
        {beq_instruction_in, flag_beq_in, mem_ack} = '0;
        alu_result_in = 0; mux2_result_in = 0; reg_rd_in = 0; mem_rdata = 0;
    endtask

    task automatic load(input bit [31:0] addr, input bit [4:0] rd);
        idle_in();
        mem_read_in = 1; mem_to_reg_in = 1; reg_write_in = 1;
        alu_result_in = addr; reg_rd_in = rd;
    endtask

    task automatic pulse_reset();
        reset = 0; #1;
        chk("rst_req", mem_req, 0);
        chk("rst_err", mem_error, 0);
        tick();
        reset = 1;
    endtask

    initial begin
        reset = 0;
        idle_in();
        tick(); tick();
        chk("reset_req", mem_req, 0);
        chk("reset_err", mem_error, 0);
        chk("reset_rw", reg_write_out, 0);
        chk("reset_stall", stall_out, 0);
        run = 1;
        reset = 1;
        tick();

        // ALU op
        reg_write_in = 1; reg_rd_in = 5; alu_result_in = 32'h10; #1;
        chk("alu_stall", stall_out, 0);
        tick();
        chk("alu_rw", reg_write_out, 1);
        chk("alu_rd", reg_rd_out, 5);
        chk("alu_res", alu_result_out, 32'h10);
        chk("alu_rdata", read_data_out, 0);

        // beq resolves combinationally
        idle_in(); beq_instruction_in = 1; flag_beq_in = 1; #1;
        chk("beq_taken", pc_src_out, 1);
        flag_beq_in = 0; #1;
        chk("beq_not_taken", pc_src_out, 0);
        tick();

        // Load at 0x40, ack on the third WAIT cycle
        load(32'h40, 7); #1;
        chk("ld_stall_issue", stall_out, 1);
        tick();
        chk("ld_req", mem_req, 1);
        chk("ld_we", mem_we, 0);
        chk("ld_addr", mem_addr, 32'h40);
        tick(); tick();
        chk("ld_stall_wait", stall_out, 1);
        chk("ld_addr_held", mem_addr, 32'h40);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; #1;
        chk("ld_stall_ack", stall_out, 0);
        tick();
        chk("ld_rdata", read_data_out, 32'hDEAD_BEEF);
        chk("ld_mtr", mem_to_reg_out, 1);
        chk("ld_rd", reg_rd_out, 7);
        chk("ld_req_drop", mem_req, 0);
        idle_in();

        // Store at 0x44, immediate ack
        mem_write_in = 1; alu_result_in = 32'h44; mux2_result_in = 32'h1234_5678;
        tick();
        chk("st_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 32'h1234_5678);
        chk("st_req", mem_req, 1);
        mem_ack = 1;
        tick();
        chk("st_rw", reg_write_out, 0);
        chk("st_req_drop", mem_req, 0);
        idle_in(); #1;
        chk("st_stall", stall_out, 0);

        // Misaligned, then read+write together
        load(32'h42, 3); #1;
        chk("mis_stall", stall_out, 0);
        tick();
        chk("mis_err", mem_error, 1);
        chk("mis_req", mem_req, 0);
        chk("mis_rw", reg_write_out, 0);
        load(32'h48, 4); mem_write_in = 1;
        tick();
        chk("rw_req", mem_req, 0);
        chk("rw_rw", reg_write_out, 0);
        idle_in();
        tick(); tick();
        chk("err_sticky", mem_error, 1);

        // Timeout with no ack
        pulse_reset();
        load(32'h80, 9);
        tick();
        for (int i = 0; i < T - 1; i++) tick();
        chk("to_last_stall", stall_out, 0);
        chk("to_last_req", mem_req, 1);
        tick();
        chk("to_req", mem_req, 0);
        chk("to_err", mem_error, 1);
        chk("to_rw", reg_write_out, 0);
        idle_in(); #1;
        chk("to_stall", stall_out, 0);

        // Ack exactly on the timeout cycle
        pulse_reset();
        load(32'h84, 10);
        tick();
        for (int i = 0; i < T - 1; i++) tick();
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        tick();
        chk("late_err", mem_error, 0);
        chk("late_rdata", read_data_out, 32'hCAFE_F00D);
        chk("late_rw", reg_write_out, 1);
        chk("late_rd", reg_rd_out, 10);
        idle_in();
        tick();

        // Reset two cycles into a load
        load(32'h90, 11);
        tick(); tick(); tick();
        idle_in(); reset = 0; #1;
        chk("rmid_req", mem_req, 0);
        chk("rmid_stall", stall_out, 0);
        chk("rmid_rw", reg_write_out, 0);
        chk("rmid_mtr", mem_to_reg_out, 0);
        tick();
        reset = 1; mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        tick();
        chk("rmid_ack_req", mem_req, 0);
        chk("rmid_ack_rdata", read_data_out, 0);
        chk("rmid_ack_rw", reg_write_out, 0);
        idle_in();
        tick(); tick();

        run = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
